// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Main controller for a multi-cycle MIPS datapath. A Moore FSM walks each
//   instruction through FETCH / DECODE / EXECUTE / MEM / WB. It steers the PC,
//   the memory, the register file and the IR/MDR/A/B/ALUOut stage registers.
//   Memory states stall on mem_ready. A stall that runs too long is aborted
//   back to FETCH. Illegal opcodes and memory aborts are reported on err.
//
// Build option:
//   MC_CONTROL_ADDI_EN  - when defined, opcode 001000 (addi) is executed
//                         through ADDI_EXEC/ADDI_WB. When undefined those states
//                         do not exist and addi is treated as illegal.
//
// Parameters:
//   MEM_TIMEOUT  (1..255) wait cycles a memory state tolerates before abort
//   ERR_STICKY   1 = err holds until reset, 0 = err is a one-cycle pulse
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   opcode[5:0]    IR[31:26], valid from DECODE onward
//   zero           ALU zero flag (conditional branch)
//   mem_ready      memory completes the current access this cycle
//   pc_en          PC load enable = pc_write | (pc_write_cond & zero)
//   i_or_d         memory address select (0 = PC, 1 = ALUOut)
//   mem_read/mem_write          memory requests
//   ir_write/mdr_write/ab_write/aluout_write   stage-register load enables
//   reg_write, reg_dst, mem_to_reg             register-file write controls
//   alu_src_a, alu_src_b[1:0], alu_op[1:0]     ALU operand/op selects
//   pc_source[1:0] next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   err            illegal opcode or memory timeout
//   state[3:0]     current state code (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned ERR_STICKY  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       err,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ILLEGAL   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

`ifdef MC_CONTROL_ADDI_EN
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
`endif

    // Compared against count+1, so one extra bit avoids wrap at 255.
    localparam logic [8:0] TIMEOUT_C    = 9'(MEM_TIMEOUT);
    localparam logic       ERR_STICKY_C = (ERR_STICKY != 32'd0);

    logic [3:0] state_r;
    logic [3:0] state_nxt_s;
    logic [7:0] wait_cnt_r;
    logic       err_r;
    logic       wait_state_s;
    logic       timeout_s;
    logic       err_event_s;
    logic       pc_write_s;
    logic       pc_write_cond_s;

    // The states that hold for a memory handshake.
    assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                          (state_r == S_MEM_WRITE);

    // The abort fires on the wait cycle that brings the count up to MEM_TIMEOUT.
    // A ready in that same cycle takes priority.
    assign timeout_s = wait_state_s && !mem_ready &&
                       (({1'b0, wait_cnt_r} + 9'd1) == TIMEOUT_C);

    assign err_event_s = timeout_s || (state_nxt_s == S_ILLEGAL);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait counter. It is zero whenever no stall is in progress, so every
    // entry to a memory state (including re-entry after an abort) starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 8'd0;
        end else if (wait_state_s && !mem_ready && !timeout_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    // Error flag. It is raised on the edge that enters ILLEGAL or that takes
    // a timeout abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (ERR_STICKY_C) begin
            err_r <= err_r | err_event_s;
        end else begin
            err_r <= err_event_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                // A timeout re-enters FETCH. The counter restarts on its own.
                if (mem_ready) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt_s = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt_s = S_R_EXEC;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_J:         state_nxt_s = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
                    OP_ADDI:      state_nxt_s = S_ADDI_EXEC;
`endif
                    default:      state_nxt_s = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_SW) begin
                    state_nxt_s = S_MEM_WRITE;
                end else begin
                    state_nxt_s = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_nxt_s = S_MEM_WB;
                end else if (timeout_s) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEM_READ;
                end
            end
            S_MEM_WRITE: begin
                if (mem_ready || timeout_s) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEM_WRITE;
                end
            end
            S_R_EXEC:    state_nxt_s = S_R_WB;
`ifdef MC_CONTROL_ADDI_EN
            S_ADDI_EXEC: state_nxt_s = S_ADDI_WB;
`endif
            // Write-back, BRANCH, JUMP, ILLEGAL and the unused codes all
            // return to FETCH.
            default:     state_nxt_s = S_FETCH;
        endcase
    end

    // Output decode. The outputs come from the state. Only the handshake
    // completions in FETCH/MEM_READ look at mem_ready.
    always_comb begin
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        mdr_write       = 1'b0;
        ab_write        = 1'b0;
        aluout_write    = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                ab_write     = 1'b1;
                aluout_write = 1'b1;
                alu_src_b    = 2'b11;
            end
            S_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
            end
            S_MEM_READ: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                mdr_write = mem_ready;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                aluout_write = 1'b1;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source       = 2'b01;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = 2'b10;
            end
`ifdef MC_CONTROL_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
`endif
            // ILLEGAL and the unused codes drive nothing.
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    assign pc_en = pc_write_s | (pc_write_cond_s & zero);
    assign err   = err_r;
    assign state = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Two instances of mc_control_fsm share one set of inputs. Both use
//   MEM_TIMEOUT=4. Instance a has a sticky err and instance b a pulsed err.
//   The reference model follows each instruction as a list of states to visit
//   and expects a fixed control word for each state. It is checked on every
//   cycle. Directed literal checks pin the main sequences.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       a_pc_en, a_i_or_d, a_mem_read, a_mem_write, a_ir_write, a_mdr_write;
    logic       a_ab_write, a_aluout_write, a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a;
    logic [1:0] a_alu_src_b, a_alu_op, a_pc_source;
    logic       a_err;
    logic [3:0] a_state;

    logic       b_pc_en, b_i_or_d, b_mem_read, b_mem_write, b_ir_write, b_mdr_write;
    logic       b_ab_write, b_aluout_write, b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a;
    logic [1:0] b_alu_src_b, b_alu_op, b_pc_source;
    logic       b_err;
    logic [3:0] b_state;

    logic [17:0] a_ctrl, b_ctrl;

    assign a_ctrl = {a_pc_en, a_i_or_d, a_mem_read, a_mem_write, a_ir_write, a_mdr_write,
                     a_ab_write, a_aluout_write, a_reg_write, a_reg_dst, a_mem_to_reg,
                     a_alu_src_a, a_alu_src_b, a_alu_op, a_pc_source};
    assign b_ctrl = {b_pc_en, b_i_or_d, b_mem_read, b_mem_write, b_ir_write, b_mdr_write,
                     b_ab_write, b_aluout_write, b_reg_write, b_reg_dst, b_mem_to_reg,
                     b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_source};

    mc_control_fsm #(.MEM_TIMEOUT(TO), .ERR_STICKY(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(a_pc_en), .i_or_d(a_i_or_d), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .mdr_write(a_mdr_write), .ab_write(a_ab_write),
        .aluout_write(a_aluout_write), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
        .mem_to_reg(a_mem_to_reg), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .alu_op(a_alu_op), .pc_source(a_pc_source), .err(a_err), .state(a_state)
    );

    mc_control_fsm #(.MEM_TIMEOUT(TO), .ERR_STICKY(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(b_pc_en), .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .ir_write(b_ir_write), .mdr_write(b_mdr_write), .ab_write(b_ab_write),
        .aluout_write(b_aluout_write), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
        .alu_op(b_alu_op), .pc_source(b_pc_source), .err(b_err), .state(b_state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the current state, the states still to visit for this
    // instruction, the stall length, and the two err flavours.
    int m_st;
    int m_wait;
    int path[$];
    bit m_err_s;
    bit m_err_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control word each state must present, in the a_ctrl bit order.
    function automatic logic [17:0] exp_ctrl(input int st, input bit mr, input bit z);
        bit pce, iod, mrd, mwr, irw, mdrw, abw, aow, rw, rd, m2r, sa;
        logic [1:0] sb, op, ps;
        pce = 0; iod = 0; mrd = 0; mwr = 0; irw = 0; mdrw = 0;
        abw = 0; aow = 0; rw = 0; rd = 0; m2r = 0; sa = 0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pce = mr; end
            1:  begin abw = 1; aow = 1; sb = 2'b11; end
            2:  begin sa = 1; sb = 2'b10; aow = 1; end
            3:  begin mrd = 1; iod = 1; mdrw = mr; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; op = 2'b10; aow = 1; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pce = z; end
            9:  begin pce = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; aow = 1; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pce, iod, mrd, mwr, irw, mdrw, abw, aow, rw, rd, m2r, sa, sb, op, ps};
    endfunction

    task automatic model_reset();
        m_st = 0; m_wait = 0; path.delete(); m_err_s = 0; m_err_p = 0;
    endtask

    // The states an instruction visits after DECODE.
    task automatic route(input logic [5:0] op);
        case (op)
            6'h23: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'h2b: begin path.push_back(2); path.push_back(5); end
            6'h00: begin path.push_back(6); path.push_back(7); end
            6'h04: path.push_back(8);
            6'h02: path.push_back(9);
`ifdef MC_CONTROL_ADDI_EN
            6'h08: begin path.push_back(10); path.push_back(11); end
`endif
            default: path.push_back(15);
        endcase
    endtask

    task automatic model_step(input bit mr, input logic [5:0] op);
        bit ev;
        ev = 0;
        if ((m_st == 0 || m_st == 3 || m_st == 5) && !mr) begin
            m_wait++;
            if (m_wait == TO) begin
                path.delete(); m_st = 0; m_wait = 0; ev = 1;
            end
        end else begin
            m_wait = 0;
            if (m_st == 0) path.push_back(1);
            else if (m_st == 1) route(op);
            if (path.size() != 0) m_st = path.pop_front();
            else m_st = 0;
            if (m_st == 15) ev = 1;
        end
        m_err_p = ev;
        m_err_s = m_err_s | ev;
    endtask

    task automatic compare_outputs();
        chk("a_state", 32'(a_state), 32'(m_st));
        chk("b_state", 32'(b_state), 32'(m_st));
        chk("a_ctrl", 32'(a_ctrl), 32'(exp_ctrl(m_st, mem_ready, zero)));
        chk("b_ctrl", 32'(b_ctrl), 32'(exp_ctrl(m_st, mem_ready, zero)));
        chk("a_err_sticky", 32'(a_err), 32'(m_err_s));
        chk("b_err_pulse", 32'(b_err), 32'(m_err_p));
    endtask

    // Called 1 time unit after a rising edge. Afterwards the time is again
    // 1 unit after the next rising edge and the model is up to date.
    task automatic tick(input bit mr, input bit z, input logic [5:0] op);
        mem_ready = mr; zero = z; opcode = op;
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_step(mr, op);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 6'h23;
            1: return 6'h2b;
            2: return 6'h00;
            3: return 6'h04;
            4: return 6'h02;
            5: return 6'h08;
            6: return 6'h3f;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_mem_read", 32'(a_mem_read), 32'd1);
        chk("rst_ir_write", 32'(a_ir_write), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_err_b", 32'(b_err), 32'd0);
        rst_n = 1'b1;

        // lw, zero-wait memory: 0,1,2,3,4,0
        tick(1, 0, 6'h23); chk("lw_s1", 32'(a_state), 32'd1);
        tick(1, 0, 6'h23); chk("lw_s2", 32'(a_state), 32'd2);
        tick(1, 0, 6'h23); chk("lw_s3", 32'(a_state), 32'd3);
        chk("lw_mdr_write", 32'(a_mdr_write), 32'd1);
        tick(1, 0, 6'h23); chk("lw_s4", 32'(a_state), 32'd4);
        chk("lw_reg_write", 32'(a_reg_write), 32'd1);
        chk("lw_mem_to_reg", 32'(a_mem_to_reg), 32'd1);
        tick(1, 0, 6'h23); chk("lw_s0", 32'(a_state), 32'd0);

        // beq, taken and then not taken
        tick(1, 1, 6'h04); tick(1, 1, 6'h04);
        chk("beq_t_state", 32'(a_state), 32'd8);
        chk("beq_t_pc_en", 32'(a_pc_en), 32'd1);
        tick(1, 1, 6'h04); chk("beq_t_ret", 32'(a_state), 32'd0);
        tick(1, 0, 6'h04); tick(1, 0, 6'h04);
        chk("beq_n_state", 32'(a_state), 32'd8);
        chk("beq_n_pc_en", 32'(a_pc_en), 32'd0);
        tick(1, 0, 6'h04); chk("beq_n_ret", 32'(a_state), 32'd0);

        // FETCH timeout: ready on the 4th wait cycle wins
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 6'h02);
        chk("to_wait_state", 32'(a_state), 32'd0);
        tick(1, 0, 6'h02);
        chk("to_rdy_state", 32'(a_state), 32'd1);
        chk("to_rdy_err", 32'(a_err), 32'd0);
        tick(1, 0, 6'h02); tick(1, 0, 6'h02);
        // FETCH timeout: 4 idle cycles abort
        for (int i = 0; i < 4; i++) tick(0, 0, 6'h02);
        chk("to_abort_state", 32'(a_state), 32'd0);
        chk("to_abort_err", 32'(a_err), 32'd1);
        chk("to_abort_err_b", 32'(b_err), 32'd1);
        tick(1, 0, 6'h02);
        chk("to_after_state", 32'(a_state), 32'd1);
        chk("to_after_err", 32'(a_err), 32'd1);
        chk("to_after_err_b", 32'(b_err), 32'd0);
        tick(1, 0, 6'h02); tick(1, 0, 6'h02);

        // illegal opcode
        do_reset();
        tick(1, 0, 6'h3f); tick(1, 0, 6'h3f);
        chk("ill_state", 32'(a_state), 32'd15);
        chk("ill_err", 32'(a_err), 32'd1);
        chk("ill_err_b", 32'(b_err), 32'd1);
        chk("ill_ctrl", 32'(a_ctrl), 32'd0);
        tick(1, 0, 6'h3f);
        chk("ill_ret", 32'(a_state), 32'd0);
        chk("ill_err_hold", 32'(a_err), 32'd1);
        chk("ill_err_b_drop", 32'(b_err), 32'd0);

        // addi
        tick(1, 0, 6'h08); tick(1, 0, 6'h08);
`ifdef MC_CONTROL_ADDI_EN
        chk("addi_exec", 32'(a_state), 32'd10);
        tick(1, 0, 6'h08);
        chk("addi_wb", 32'(a_state), 32'd11);
        chk("addi_reg_write", 32'(a_reg_write), 32'd1);
        chk("addi_mem_to_reg", 32'(a_mem_to_reg), 32'd0);
`else
        chk("addi_illegal", 32'(a_state), 32'd15);
        chk("addi_err_b", 32'(b_err), 32'd1);
`endif
        tick(1, 0, 6'h08);
        chk("addi_ret", 32'(a_state), 32'd0);

        // asynchronous reset in the middle of MEM_READ (err_a is already set)
        tick(1, 0, 6'h23); tick(1, 0, 6'h23); tick(0, 0, 6'h23); tick(0, 0, 6'h23);
        chk("ar_pre_state", 32'(a_state), 32'd3);
        #2 rst_n = 1'b0; mem_ready = 1'b0;
        #1;
        chk("ar_state", 32'(a_state), 32'd0);
        chk("ar_mem_read", 32'(a_mem_read), 32'd1);
        chk("ar_i_or_d", 32'(a_i_or_d), 32'd0);
        chk("ar_err", 32'(a_err), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // randomized traffic
        op = pick_op();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            if (m_st == 0) op = pick_op();
            tick(($urandom_range(0, 9) < 6), 1'($urandom), op);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
